// File: rtl/cart_mapper.sv
// cart_mapper: MSX cartridge bank mapper. It turns CPU slot accesses into
// registered ROM byte addresses for the no-mapper, Konami, Konami SCC, ASCII8
// and ASCII16 cartridge types, and it flags the SCC register window.
module cart_mapper #(
  parameter int AW        = 25,
  parameter int BANK_BITS = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    mapper,
  input  logic [AW-1:0] rom_size,
  input  logic [3:0]    offset,
  input  logic [15:0]   addr,
  input  logic [7:0]    d_from_cpu,
  input  logic          wr,
  input  logic          rd,
  input  logic          cs,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          scc_sel
);

  localparam logic [2:0] M_KONAMI  = 3'd3;
  localparam logic [2:0] M_SCC     = 3'd4;
  localparam logic [2:0] M_ASCII8  = 3'd5;
  localparam logic [2:0] M_ASCII16 = 3'd6;

  // One ROM access as it is presented to the memory store
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          rd;
    logic          scc;
  } mem_req_t;

  logic [3:0][BANK_BITS-1:0] bank;
  logic [3:0][BANK_BITS-1:0] bank_dflt;
  logic [3:0]                wsel;
  logic [2:0]                mapper_q;
  logic                      wr_q;
  logic                      reload;
  logic                      wr_edge;

  logic [1:0]           page;
  logic [BANK_BITS-1:0] b8;
  logic [BANK_BITS-1:0] b16;
  logic [AW-1:0]        mask8;
  logic [AW-1:0]        mask16;
  logic [AW-1:0]        a8;
  logic [AW-1:0]        a16;
  logic [15:0]          off_bytes;
  logic [AW-1:0]        a_nm;
  logic                 win;
  logic                 nm_in;
  logic                 scc_hit;
  logic                 in_range;
  mem_req_t             nxt;

  // Power-on bank contents: Konami types map banks 0..3 straight through,
  // ASCII types (and the unmapped types) start at bank 0 everywhere.
  function automatic logic [3:0][BANK_BITS-1:0] bank_defaults(input logic [2:0] m);
    logic [3:0][BANK_BITS-1:0] d;
    d = '0;
    if (m == M_KONAMI || m == M_SCC)
      for (int i = 0; i < 4; i++) d[i] = BANK_BITS'(i);
    return d;
  endfunction

  assign bank_dflt = bank_defaults(mapper);
  assign reload    = (mapper != mapper_q);
  assign wr_edge   = cs & wr & ~wr_q;

  // Write-strobe history and last-seen mapper type for edge/change detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q     <= 1'b0;
      mapper_q <= mapper;
    end else begin
      wr_q     <= wr;
      mapper_q <= mapper;
    end
  end

  // Decode which bank register a freshly detected CPU write targets
  always_comb begin
    wsel = '0;
    if (wr_edge) begin
      case (mapper)
        M_KONAMI: begin
          case (addr[15:13])
            3'd3:    wsel[1] = 1'b1;
            3'd4:    wsel[2] = 1'b1;
            3'd5:    wsel[3] = 1'b1;
            default: ;
          endcase
        end
        M_SCC: begin
          case (addr[15:11])
            5'b01010: wsel[0] = 1'b1;
            5'b01110: wsel[1] = 1'b1;
            5'b10010: wsel[2] = 1'b1;
            5'b10110: wsel[3] = 1'b1;
            default:  ;
          endcase
        end
        M_ASCII8: begin
          case (addr[15:11])
            5'b01100: wsel[0] = 1'b1;
            5'b01101: wsel[1] = 1'b1;
            5'b01110: wsel[2] = 1'b1;
            5'b01111: wsel[3] = 1'b1;
            default:  ;
          endcase
        end
        M_ASCII16: begin
          case (addr[15:11])
            5'b01100: wsel[0] = 1'b1;
            5'b01110: wsel[1] = 1'b1;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Bank registers; reset and a mapper change both reload defaults and
  // take priority over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n || reload) begin
      bank <= bank_dflt;
    end else begin
      for (int i = 0; i < 4; i++)
        if (wsel[i]) bank[i] <= BANK_BITS'(d_from_cpu);
    end
  end

  // Address generation for every mapper type, selected by the current type
  always_comb begin
    // 4000h..BFFFh -> pages 0..3; the low two page bits wrap to the same result
    page      = addr[14:13] - 2'd2;
    b8        = bank[page];
    b16       = bank[{1'b0, addr[15]}];
    mask8     = (rom_size - AW'(1)) >> 13;
    mask16    = (rom_size - AW'(1)) >> 14;
    a8        = ((AW'(b8) & mask8) << 13) | AW'(addr[12:0]);
    a16       = ((AW'(b16) & mask16) << 14) | AW'(addr[13:0]);
    off_bytes = {offset, 12'h000};
    a_nm      = AW'(addr) - AW'(off_bytes);
    win       = (addr >= 16'h4000) && (addr <= 16'hBFFF);
    nm_in     = (addr >= off_bytes) && (a_nm < rom_size);
    // SCC registers appear at 9800h..9FFFh once bank 2 selects 3Fh
    scc_hit   = cs && (mapper == M_SCC) && (bank[2][5:0] == 6'h3F) &&
                (addr[15:11] == 5'b10011);

    nxt      = '0;
    in_range = 1'b0;
    case (mapper)
      M_KONAMI, M_SCC, M_ASCII8: begin
        nxt.addr = a8;
        in_range = win;
      end
      M_ASCII16: begin
        nxt.addr = a16;
        in_range = win;
      end
      default: begin
        nxt.addr = a_nm;
        in_range = nm_in;
      end
    endcase
    nxt.scc = scc_hit;
    nxt.rd  = cs & rd & in_range & ~scc_hit;
  end

  // Registered memory request: one clock from CPU address to ROM address
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      scc_sel  <= 1'b0;
    end else begin
      mem_addr <= nxt.addr;
      mem_rd   <= nxt.rd;
      scc_sel  <= nxt.scc;
    end
  end

endmodule
